dbus_periph_bridge: RTL
=======================

# dbus_periph_bridge

Data-bus bridge between the VexRiscv `dBus` master port and the simulation data RAM. It decodes each command by address: RAM traffic passes through, while a small MMIO window provides a buffered console, a halt/exit register and a 64-bit machine timer that drives the CPU's `timerInterrupt`. All load responses are registered, so every read returns exactly one cycle after acceptance.

## Interface
- `CONSOLE_DEPTH`, 4: console FIFO entries (power of two, ≥2).
- `TIMER_PRESCALE`, 1: `clk` cycles per `mtime` increment (≥1).
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `dBus_cmd_valid` / `dBus_cmd_ready` in/out 1: CPU command handshake.
- `dBus_cmd_payload_wr` in 1: 1 = store.
- `dBus_cmd_payload_address` in 32: byte address.
- `dBus_cmd_payload_data` in 32: store data.
- `dBus_cmd_payload_size` in 2: 0 = byte, 1 = half, 2 = word.
- `dBus_rsp_ready` out 1: load data valid (one-cycle pulse).
- `dBus_rsp_error` out 1: qualifies `dBus_rsp_ready`.
- `dBus_rsp_data` out 32: load data.
- `ram_cmd_valid` / `ram_cmd_ready` out/in 1: RAM-side handshake.
- `ram_cmd_payload_wr`, `ram_cmd_payload_address[31:0]`, `ram_cmd_payload_data[31:0]`, `ram_cmd_payload_size[1:0]` out: copies of the CPU command.
- `ram_rsp_data` in 32: combinational RAM read data for the current address.
- `console_valid` / `console_ready` out/in 1: console byte stream handshake.
- `console_data` out 8: FIFO head byte.
- `halted` out 1: sticky; set by a HALT write.
- `exit_code` out 32: value written to HALT.
- `bus_fault` out 1: sticky; set by an erroneous store.
- `timerInterrupt` out 1: registered `mtime >= mtimecmp`.

## Operation
- **Address decode.**
  - RAM: `0x8000_0000`–`0x8FFF_FFFF`.
  - MMIO (word offsets from `0xF000_0000`): `0x00` CONSOLE, `0x04` HALT, `0x08`/`0x0C` MTIME lo/hi, `0x10`/`0x14` MTIMECMP lo/hi.
  - Anything else: unmapped.
- **RAM path.**
  - `ram_cmd_valid = dBus_cmd_valid & sel_ram`; `dBus_cmd_ready = ram_cmd_ready` while RAM is selected.
  - On an accepted read, `ram_rsp_data` is captured into the response register.
- **MMIO path.**
  - `dBus_cmd_ready = 1`, except for a CONSOLE store while the FIFO is full: ready stays 0 until an entry drains.
  - Stores:
    - CONSOLE accepts size 0 or 2 and pushes `data[7:0]`.
    - All other registers accept size 2 only and write the full word.
    - Any other size, or an unmapped address, is dropped and sets `bus_fault`.
  - Loads:
    - CONSOLE returns `{30'b0, fifo_full, fifo_empty}`.
    - HALT returns `exit_code`.
    - MTIME/MTIMECMP return their halves.
    - An unmapped load, or an MMIO load with size ≠ 2, returns data 0 with `dBus_rsp_error = 1`.
- **Console FIFO.**
  - Circular buffer of `CONSOLE_DEPTH` entries. Pointers are one bit wider than the index so full and empty are distinguishable.
  - Push and pop in the same cycle is legal when the FIFO is not empty; occupancy is unchanged.
  - `console_valid = !empty`.
- **Timer.**
  - A prescale counter wraps at `TIMER_PRESCALE-1`; at wrap, `mtime` increments with 64-bit wrap-around.
  - A CPU write to a MTIME half overrides that cycle's increment for that half only.
  - `timerInterrupt` is registered from an unsigned 64-bit compare.
- **Halt.**
  - A HALT store sets `halted` and loads `exit_code`.
  - Later stores overwrite `exit_code`; `halted` stays 1.
  - The bridge keeps servicing commands after halt.

## Timing
- Reset values:
  - `dBus_rsp_ready`, `dBus_rsp_error`, `dBus_rsp_data`: 0.
  - `console_valid`: 0; `console_data`: 0; FIFO empty.
  - `halted`, `exit_code`, `bus_fault`: 0.
  - `mtime`: 0; `mtimecmp`: all ones; `timerInterrupt`: 0.
- Read latency:
  - A read accepted at edge N gives `dBus_rsp_ready = 1` for the cycle after N, then 0.
  - A new command may be accepted in that response cycle, giving back-to-back reads at one per cycle.
- Stores produce no response.
- MMIO store effects are visible to a load accepted on the next edge.
- `timerInterrupt` rises one cycle after `mtime` reaches `mtimecmp`.
- `reset` asserted mid-transaction: any pending response is dropped (`dBus_rsp_ready` cleared asynchronously) and all state is cleared.

## Test plan
- **RAM read:** store word `0xDEADBEEF` to `0x8000_0010`, then load it → `dBus_rsp_ready` exactly 1 cycle after the load is accepted, data `0xDEADBEEF`, error 0.
- **Console backpressure:** hold `console_ready = 0`, issue 5 byte stores `'A'..'E'` (depth 4) → first 4 accepted, 5th stalls with `dBus_cmd_ready = 0`. Raise `console_ready` → bytes emerge `'A','B','C','D','E'` in order, and the 5th store is accepted after the first pop.
- **Timer interrupt:** `TIMER_PRESCALE = 1`, write MTIMECMP lo = 20, hi = 0, MTIME = 0 → `timerInterrupt` rises in the cycle after `mtime` equals 20. Writing MTIMECMP hi = `0xFFFFFFFF` → it drops the next cycle.
- **Unmapped access:** load from `0x1000_0000` → rsp error 1, data 0. Store to `0xF000_0040` → `bus_fault = 1`, no response.
- **Halt:** store `0x2A` to `0xF000_0004` → `halted = 1` and `exit_code = 0x2A` on the next cycle. A following load of `0xF000_0004` returns `0x2A`.
- **Reset mid-read:** assert `reset` low in the cycle after a read is accepted → `dBus_rsp_ready` falls immediately, FIFO is empty, `mtime = 0`.

Source files
------------

// File: rtl/dbus_periph_bridge_if.sv
// VexRiscv dBus command/response bundle: CPU side is master, bridge side is slave.
// Responses carry no handshake; the master must accept every response pulse.
interface dbus_periph_bridge_if;
  logic        dBus_cmd_valid;
  logic        dBus_cmd_ready;
  logic        dBus_cmd_payload_wr;
  logic [31:0] dBus_cmd_payload_address;
  logic [31:0] dBus_cmd_payload_data;
  logic [1:0]  dBus_cmd_payload_size;
  logic        dBus_rsp_ready;
  logic        dBus_rsp_error;
  logic [31:0] dBus_rsp_data;

  modport master (
    output dBus_cmd_valid, dBus_cmd_payload_wr, dBus_cmd_payload_address,
           dBus_cmd_payload_data, dBus_cmd_payload_size,
    input  dBus_cmd_ready, dBus_rsp_ready, dBus_rsp_error, dBus_rsp_data
  );

  modport slave (
    input  dBus_cmd_valid, dBus_cmd_payload_wr, dBus_cmd_payload_address,
           dBus_cmd_payload_data, dBus_cmd_payload_size,
    output dBus_cmd_ready, dBus_rsp_ready, dBus_rsp_error, dBus_rsp_data
  );
endinterface

// File: rtl/dbus_periph_bridge.sv
// dBus bridge: RAM pass-through plus MMIO console FIFO, halt register and 64-bit machine timer.
// Loads respond exactly one cycle after acceptance; stalls only on RAM backpressure or a full console.
module dbus_periph_bridge #(
  parameter int CONSOLE_DEPTH  = 4,
  parameter int TIMER_PRESCALE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  dbus_periph_bridge_if.slave  dbus,
  output logic                 ram_cmd_valid,
  input  logic                 ram_cmd_ready,
  output logic                 ram_cmd_payload_wr,
  output logic [31:0]          ram_cmd_payload_address,
  output logic [31:0]          ram_cmd_payload_data,
  output logic [1:0]           ram_cmd_payload_size,
  input  logic [31:0]          ram_rsp_data,
  output logic                 console_valid,
  input  logic                 console_ready,
  output logic [7:0]           console_data,
  output logic                 halted,
  output logic [31:0]          exit_code,
  output logic                 bus_fault,
  output logic                 timerInterrupt
);

  localparam int AW = $clog2(CONSOLE_DEPTH);
  localparam int PW = (TIMER_PRESCALE > 1) ? $clog2(TIMER_PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TIMER_PRESCALE - 1);

  logic [31:0] addr, wdata;
  logic [1:0]  size;
  logic        is_wr;

  assign addr  = dbus.dBus_cmd_payload_address;
  assign wdata = dbus.dBus_cmd_payload_data;
  assign size  = dbus.dBus_cmd_payload_size;
  assign is_wr = dbus.dBus_cmd_payload_wr;

  logic [2:0] reg_idx;
  logic       sel_ram, in_win, sel_mmio, sel_con, size_word;

  assign reg_idx   = addr[4:2];
  assign sel_ram   = (addr[31:28] == 4'h8);
  assign in_win    = (addr[31:5] == 27'h780_0000);
  assign sel_mmio  = in_win && (reg_idx <= 3'd5);
  assign sel_con   = sel_mmio && (reg_idx == 3'd0);
  assign size_word = (size == 2'd2);

  // State registers
  logic              rsp_vld_q, rsp_vld_d, rsp_err_q, rsp_err_d;
  logic [31:0]       rsp_dat_q, rsp_dat_d;
  logic [7:0]        fifo_q [CONSOLE_DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [63:0]       mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic              irq_q, irq_d, halted_q, halted_d, fault_q, fault_d;
  logic [31:0]       exit_q, exit_d;

  logic fifo_full, fifo_empty;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Only a console store into a full FIFO stalls on the MMIO side.
  logic con_stall, cmd_acc, acc_wr, acc_rd;
  assign con_stall            = sel_con && is_wr && fifo_full;
  assign dbus.dBus_cmd_ready  = sel_ram ? ram_cmd_ready : !con_stall;
  assign cmd_acc              = dbus.dBus_cmd_valid && dbus.dBus_cmd_ready;
  assign acc_wr               = cmd_acc && is_wr;
  assign acc_rd               = cmd_acc && !is_wr;

  assign ram_cmd_valid           = dbus.dBus_cmd_valid && sel_ram;
  assign ram_cmd_payload_wr      = is_wr;
  assign ram_cmd_payload_address = addr;
  assign ram_cmd_payload_data    = wdata;
  assign ram_cmd_payload_size    = size;

  logic push, pop, wr_reg, wr_halt, wr_mtl, wr_mth, wr_cmpl, wr_cmph, st_fault, tick;
  assign push     = acc_wr && sel_con && (size == 2'd0 || size_word);
  assign pop      = console_valid && console_ready;
  assign wr_reg   = acc_wr && sel_mmio && !sel_con && size_word;
  assign wr_halt  = wr_reg && (reg_idx == 3'd1);
  assign wr_mtl   = wr_reg && (reg_idx == 3'd2);
  assign wr_mth   = wr_reg && (reg_idx == 3'd3);
  assign wr_cmpl  = wr_reg && (reg_idx == 3'd4);
  assign wr_cmph  = wr_reg && (reg_idx == 3'd5);
  assign st_fault = acc_wr && !sel_ram && !push && !wr_reg;
  assign tick     = (presc_q == PRESC_MAX);

  always_comb begin
    rsp_vld_d  = acc_rd;
    rsp_err_d  = 1'b0;
    rsp_dat_d  = 32'h0;
    wr_ptr_d   = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d   = rd_ptr_q + (AW+1)'(pop);
    presc_d    = tick ? '0 : presc_q + PW'(1);
    mtime_d    = mtime_q + 64'(tick);
    mtimecmp_d = mtimecmp_q;
    irq_d      = (mtime_q >= mtimecmp_q);
    halted_d   = halted_q || wr_halt;
    exit_d     = wr_halt ? wdata : exit_q;
    fault_d    = fault_q || st_fault;

    if (acc_rd) begin
      if (sel_ram) begin
        rsp_dat_d = ram_rsp_data;
      end else if (sel_mmio && size_word) begin
        case (reg_idx)
          3'd0:    rsp_dat_d = {30'b0, fifo_full, fifo_empty};
          3'd1:    rsp_dat_d = exit_q;
          3'd2:    rsp_dat_d = mtime_q[31:0];
          3'd3:    rsp_dat_d = mtime_q[63:32];
          3'd4:    rsp_dat_d = mtimecmp_q[31:0];
          3'd5:    rsp_dat_d = mtimecmp_q[63:32];
          default: rsp_dat_d = 32'h0;
        endcase
      end else begin
        rsp_err_d = 1'b1;
      end
    end

    // A CPU write to one mtime half replaces that half of the incremented value.
    if (wr_mtl)  mtime_d[31:0]     = wdata;
    if (wr_mth)  mtime_d[63:32]    = wdata;
    if (wr_cmpl) mtimecmp_d[31:0]  = wdata;
    if (wr_cmph) mtimecmp_d[63:32] = wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_vld_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
      rsp_dat_q  <= 32'h0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      presc_q    <= '0;
      mtime_q    <= 64'h0;
      mtimecmp_q <= '1;
      irq_q      <= 1'b0;
      halted_q   <= 1'b0;
      exit_q     <= 32'h0;
      fault_q    <= 1'b0;
      for (int i = 0; i < CONSOLE_DEPTH; i++) fifo_q[i] <= 8'h0;
    end else begin
      rsp_vld_q  <= rsp_vld_d;
      rsp_err_q  <= rsp_err_d;
      rsp_dat_q  <= rsp_dat_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      irq_q      <= irq_d;
      halted_q   <= halted_d;
      exit_q     <= exit_d;
      fault_q    <= fault_d;
      if (push) fifo_q[wr_ptr_q[AW-1:0]] <= wdata[7:0];
    end
  end

  assign dbus.dBus_rsp_ready = rsp_vld_q;
  assign dbus.dBus_rsp_error = rsp_err_q;
  assign dbus.dBus_rsp_data  = rsp_dat_q;
  assign console_valid       = !fifo_empty;
  assign console_data        = fifo_q[rd_ptr_q[AW-1:0]];
  assign halted              = halted_q;
  assign exit_code           = exit_q;
  assign bus_fault           = fault_q;
  assign timerInterrupt      = irq_q;

endmodule
